// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: occupancy
// state encoding and the EX/MEM control-bundle bit layout.
package pipe_pkg;

  // Occupancy state encoding of the stage.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b10;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,  // nothing held
    S_FULL  = ST_FULL,   // main register holds a bundle
    S_SKID  = ST_SKID    // main and skid registers both hold bundles
  } stage_state_e;

  // EX/MEM control-bundle bit positions; the bundle is 7 bits wide.
  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_MEMTOREG     = 1;
  localparam int CTRL_MEMWRITE     = 2;
  localparam int CTRL_MEMREAD      = 3;
  localparam int CTRL_JUMP         = 4;
  localparam int CTRL_DATATYPE_LSB = 5;
  localparam int CTRL_DATATYPE_MSB = 6;
  localparam int EXMEM_CTRL_W      = CTRL_DATATYPE_MSB + 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count events, stick at all-ones, clear on request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline stage register with valid/ready handshake, a 2-entry skid
// buffer (main + skid) so In_Ready can be a plain flop, synchronous flush
// for bubble insertion, and a saturating stall-cycle counter.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  input  logic              Cnt_Clr,
  output logic [CNT_W-1:0]  Stall_Count
);

  stage_state_e r_state;
  stage_state_e w_state_next;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_accept;
  logic w_emit;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_clr_main_ctrl;
  logic w_stall;

  assign w_accept = In_Valid & r_in_ready;
  assign w_emit   = r_out_valid & Out_Ready;

  // Next-state and register-load decisions; flush overrides any handshake.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clr_main_ctrl  = 1'b0;
    if (Flush) begin
      w_state_next    = S_EMPTY;
      w_clr_main_ctrl = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_state_next   = S_FULL;
          end
        end
        S_FULL: begin
          if (w_emit && w_accept) begin
            w_load_main_in = 1'b1;
          end else if (w_emit) begin
            w_clr_main_ctrl = 1'b1;
            w_state_next    = S_EMPTY;
          end else if (w_accept) begin
            w_load_skid  = 1'b1;
            w_state_next = S_SKID;
          end
        end
        S_SKID: begin
          // In_Ready is low here, so nothing can be accepted.
          if (w_emit) begin
            w_load_main_skid = 1'b1;
            w_state_next     = S_FULL;
          end
        end
        default: begin
          w_clr_main_ctrl = 1'b1;
          w_state_next    = S_EMPTY;
        end
      endcase
    end
  end

  // State register plus flopped handshake outputs decoded from the next state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != S_SKID);
      r_out_valid <= (w_state_next != S_EMPTY);
    end
  end

  // Main register: load from input or skid; control zeroed when it goes empty.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (w_clr_main_ctrl) begin
      r_main_ctrl <= '0;
    end else if (w_load_main_in) begin
      r_main_ctrl <= In_Ctrl;
      r_main_data <= In_Data;
    end else if (w_load_main_skid) begin
      r_main_ctrl <= r_skid_ctrl;
      r_main_data <= r_skid_data;
    end
  end

  // Skid register: captures the bundle accepted while downstream stalls.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (w_load_skid) begin
      r_skid_ctrl <= In_Ctrl;
      r_skid_data <= In_Data;
    end
  end

  assign w_stall = r_out_valid & ~Out_Ready;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_inc   (w_stall),
    .i_clr   (Cnt_Clr),
    .o_count (Stall_Count)
  );

  assign In_Ready  = r_in_ready;
  assign Out_Valid = r_out_valid;
  assign Out_Ctrl  = r_main_ctrl;
  assign Out_Data  = r_main_data;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

  localparam int CTRL_W  = 7;
  localparam int DATA_W  = 128;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              Clk;
  logic              Rst_n;
  logic              In_Valid;
  logic              In_Ready;
  logic [CTRL_W-1:0] In_Ctrl;
  logic [DATA_W-1:0] In_Data;
  logic              Flush;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic              Cnt_Clr;
  logic [CNT_W-1:0]  Stall_Count;

  pipe_stage_skid_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .In_Ctrl     (In_Ctrl),
    .In_Data     (In_Data),
    .Flush       (Flush),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .Out_Ctrl    (Out_Ctrl),
    .Out_Data    (Out_Data),
    .Cnt_Clr     (Cnt_Clr),
    .Stall_Count (Stall_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two bundles.
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t m_q[$];
  int   m_cnt;
  bit   m_acc;
  bit   m_emt;
  ent_t m_new;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      m_acc = In_Valid && (m_q.size() < 2);
      m_emt = (m_q.size() > 0) && Out_Ready;
      if (Cnt_Clr) m_cnt = 0;
      else if ((m_q.size() > 0) && !Out_Ready && (m_cnt < CNT_MAX)) m_cnt = m_cnt + 1;
      if (Flush) begin
        m_q.delete();
      end else begin
        if (m_emt) void'(m_q.pop_front());
        if (m_acc) begin
          m_new.c = In_Ctrl;
          m_new.d = In_Data;
          m_q.push_back(m_new);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (Rst_n) begin
      check("in_ready", {127'b0, In_Ready}, {127'b0, (m_q.size() < 2)});
      check("out_valid", {127'b0, Out_Valid}, {127'b0, (m_q.size() > 0)});
      if (m_q.size() > 0) begin
        check("out_ctrl", Out_Ctrl, m_q[0].c);
        check("out_data", Out_Data, m_q[0].d);
      end else begin
        check("out_ctrl_bubble", Out_Ctrl, 0);
      end
      check("stall_count", Stall_Count, m_cnt);
    end
  end

  task automatic set_in(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl, input logic clr);
    In_Valid  = v;
    In_Ctrl   = c;
    In_Data   = d;
    Out_Ready = ordy;
    Flush     = fl;
    Cnt_Clr   = clr;
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  initial begin
    Rst_n = 1'b0;
    set_in(0, '0, '0, 0, 0, 0);
    repeat (2) step();
    check("rst_out_valid", {127'b0, Out_Valid}, 0);
    check("rst_in_ready", {127'b0, In_Ready}, 1);
    check("rst_out_ctrl", Out_Ctrl, 0);
    check("rst_out_data", Out_Data, 0);
    check("rst_stall", Stall_Count, 0);
    Rst_n = 1'b1;

    // One bundle through an empty stage: one cycle of latency.
    set_in(1, 7'h01, 128'hA5, 1, 0, 0);
    step();
    check("first_valid", {127'b0, Out_Valid}, 1);
    check("first_ctrl", Out_Ctrl, 7'h01);
    check("first_data", Out_Data, 128'hA5);
    check("first_in_ready", {127'b0, In_Ready}, 1);
    set_in(0, '0, '0, 1, 0, 0);
    step();
    check("drain_valid", {127'b0, Out_Valid}, 0);
    check("drain_ctrl", Out_Ctrl, 0);

    // Back-to-back stream, no bubbles.
    for (int i = 1; i <= 8; i++) begin
      set_in(1, CTRL_W'(i), DATA_W'(i), 1, 0, 0);
      step();
      check("stream_valid", {127'b0, Out_Valid}, 1);
      check("stream_data", Out_Data, DATA_W'(i));
    end
    set_in(0, '0, '0, 1, 0, 0);
    step();
    check("stream_stall", Stall_Count, 0);

    // Fill skid with downstream stalled, then release in order.
    set_in(1, 7'h01, 128'd1, 0, 0, 0);
    step();
    check("skid_l1_data", Out_Data, 1);
    set_in(1, 7'h02, 128'd2, 0, 0, 0);
    step();
    check("skid_in_ready", {127'b0, In_Ready}, 0);
    check("skid_out_data", Out_Data, 1);
    check("skid_stall1", Stall_Count, 1);
    set_in(0, '0, '0, 0, 0, 0);
    repeat (2) step();
    check("skid_stall3", Stall_Count, 3);
    set_in(0, '0, '0, 1, 0, 0);
    step();
    check("skid_second", Out_Data, 2);
    check("skid_ready_back", {127'b0, In_Ready}, 1);
    step();
    check("skid_empty", {127'b0, Out_Valid}, 0);

    // Flush from SKID while a new bundle is offered.
    set_in(1, 7'h01, 128'd1, 0, 0, 0);
    step();
    set_in(1, 7'h02, 128'd2, 0, 0, 0);
    step();
    check("fl_pre_ready", {127'b0, In_Ready}, 0);
    set_in(1, 7'h7f, 128'd9, 0, 1, 0);
    step();
    check("fl_valid", {127'b0, Out_Valid}, 0);
    check("fl_ctrl", Out_Ctrl, 0);
    check("fl_ready", {127'b0, In_Ready}, 1);
    check("fl_stall", Stall_Count, 5);
    set_in(0, '0, '0, 1, 0, 0);
    repeat (3) begin
      step();
      check("fl_no_ghost", {127'b0, Out_Valid}, 0);
    end

    // Counter saturation and clear.
    set_in(0, '0, '0, 0, 0, 1);
    step();
    check("clr_zero", Stall_Count, 0);
    set_in(1, 7'h03, 128'h33, 0, 0, 0);
    step();
    set_in(0, '0, '0, 0, 0, 0);
    repeat ((1 << CNT_W) + 5) step();
    check("sat_max", Stall_Count, CNT_MAX);
    set_in(0, '0, '0, 0, 0, 1);
    step();
    check("sat_clr", Stall_Count, 0);
    set_in(0, '0, '0, 1, 0, 0);
    step();

    // Random traffic, checked by the per-cycle compare.
    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom_range(0, 99) < 70), CTRL_W'($urandom), {$urandom, $urandom, $urandom, $urandom},
             ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 2));
      step();
    end
    set_in(0, '0, '0, 1, 0, 0);
    repeat (3) step();

    // Asynchronous reset in the middle of a cycle while FULL.
    set_in(1, 7'h05, 128'h55, 0, 0, 1);
    step();
    set_in(0, '0, '0, 0, 0, 0);
    repeat (2) step();
    check("prerst_stall", Stall_Count, 2);
    check("prerst_valid", {127'b0, Out_Valid}, 1);
    @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_valid", {127'b0, Out_Valid}, 0);
    check("arst_ctrl", Out_Ctrl, 0);
    check("arst_data", Out_Data, 0);
    check("arst_stall", Stall_Count, 0);
    check("arst_ready", {127'b0, In_Ready}, 1);
    step();
    Rst_n = 1'b1;
    set_in(1, 7'h02, 128'h77, 1, 0, 0);
    step();
    check("post_rst_valid", {127'b0, Out_Valid}, 1);
    check("post_rst_data", Out_Data, 128'h77);
    set_in(0, '0, '0, 1, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic pipeline stage register; next generation of our fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the single Ld enable with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a fully registered In_Ready.
- Adds synchronous Flush (bubble insertion) and a saturating stall-cycle counter for performance measurement.

Parameters:
- CTRL_W, 7, width of the control bundle (RegWrite, MemtoReg, MemWrite, MemRead, Jump, Datatype…); bubble value is all-zero.
- DATA_W, 128, width of the datapath bundle (e.g. ALUResult, ReadData2, PCAddResult, Instruction concatenated).
- CNT_W, 16, width of Stall_Count.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- In_Valid  in  1  upstream has a valid bundle.
- In_Ready  out  1  stage can accept; registered output.
- In_Ctrl  in  CTRL_W  upstream control bundle.
- In_Data  in  DATA_W  upstream datapath bundle.
- Flush  in  1  synchronous kill of all held entries.
- Out_Valid  out  1  Out_Ctrl/Out_Data valid.
- Out_Ready  in  1  downstream accepts.
- Out_Ctrl  out  CTRL_W  control to next stage; all-zero whenever Out_Valid=0.
- Out_Data  out  DATA_W  datapath to next stage.
- Cnt_Clr  in  1  synchronous clear of Stall_Count.
- Stall_Count  out  CNT_W  cycles with Out_Valid=1 and Out_Ready=0.

Behaviour:
- Storage: main register (drives outputs) and skid register; both are plain registers, no combinational in→out path.
- States:
  - EMPTY: no entries; Out_Valid=0, In_Ready=1.
  - FULL: main only; Out_Valid=1, In_Ready=1.
  - SKID: main + skid; Out_Valid=1, In_Ready=0.
- Accept = In_Valid & In_Ready. Emit = Out_Valid & Out_Ready.
- Transitions (no Flush):
  - EMPTY: Accept → main<=In, FULL; else stay.
  - FULL:
    - Emit & Accept → main<=In, stay FULL.
    - Emit & !Accept → EMPTY, main ctrl<=0.
    - !Emit & Accept → skid<=In, SKID.
    - Otherwise hold.
  - SKID: Emit → main<=skid, FULL; else hold. Accept cannot occur.
- Latency: 1 cycle In→Out from EMPTY. Sustained throughput 1 bundle/cycle when Out_Ready=1.
- Order is strictly FIFO; no bundle is ever duplicated or dropped except by Flush.
- Flush (highest priority, over any handshake):
  - Next state EMPTY; main ctrl<=0.
  - A bundle presented with Accept in the Flush cycle is discarded.
  - Out_Data and skid contents are held (don't-care).
  - In_Ready=1 in the following cycle.
- Emit in the Flush cycle still counts as delivered to downstream; Flush affects only the next state.
- Out_Ctrl is all-zero in every cycle Out_Valid=0, so downstream write enables are never spuriously asserted.
- Stall_Count:
  - +1 on each cycle with Out_Valid & !Out_Ready.
  - Saturates at 2^CNT_W-1.
  - Cnt_Clr has priority over increment and zeroes the counter on the next edge.
  - Flush does not affect the counter.
- Reset (Rst_n=0, asynchronous, any time including mid-transfer):
  - State EMPTY, Out_Valid=0, In_Ready=1.
  - Out_Ctrl=0, Out_Data=0, skid=0, Stall_Count=0.
- Release from reset is synchronous to Clk; first Accept is possible on the first edge after release.

Decomposition:
- Shared package pipe_pkg:
  - State localparams ST_EMPTY=2'b00, ST_FULL=2'b01, ST_SKID=2'b10.
  - Control-bundle bit positions for the EX/MEM bundle (RegWrite=0, MemtoReg=1, MemWrite=2, MemRead=3, Jump=4, Datatype=6:5), so CTRL_W=7 matches.
- One sub-module: pipe_sat_counter (CNT_W parameter, inc, clr, async active-low reset), instantiated for Stall_Count.

Test Plan:
- Reset then In_Valid=1, In_Ctrl=7'h01, In_Data=128'hA5, Out_Ready=1 → next cycle Out_Valid=1, Out_Ctrl=7'h01, Out_Data=128'hA5; In_Ready stays 1.
- Stream 8 bundles (data 1..8), Out_Ready=1 every cycle → outputs 1..8 on 8 consecutive cycles, no bubbles, Stall_Count=0.
- Load data 1, 2 with Out_Ready=0 → state SKID, In_Ready=0, Out_Data=1. Hold 3 cycles → Stall_Count=3. Then Out_Ready=1 → 1 then 2 emitted in order, In_Ready returns 1.
- From SKID, assert Flush with In_Valid=1, data 9 → next cycle Out_Valid=0, Out_Ctrl=0, In_Ready=1; bundle 9 never appears.
- Out_Valid=1, Out_Ready=0 held 2^CNT_W+5 cycles (CNT_W=4 build) → Stall_Count=15. Cnt_Clr pulse → 0 next cycle.
- Drop Rst_n mid-cycle while in FULL → Out_Valid, Out_Ctrl, Out_Data, Stall_Count go to 0 immediately (before the next Clk edge); In_Ready=1.
